rr_arbiter4: RTL

//  Round-robin arbiter that shares one 4-input resource between 4 requesters.

---
 rtl/rr_arbiter4.sv | 60 ++++++
 1 files changed

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: 4-way round-robin arbiter with registered one-hot grant and encoded index.
// Define ARB_TIMEOUT_EN to force release after HOLD_MAX grant cycles and pulse timeout.
module rr_arbiter4 #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nx;
  logic [1:0] ptr, win;
  logic rel, tmo;
  if (HOLD_MAX < 1 || HOLD_MAX > (1 << CNT_W) - 1) begin : g_bad_hold
    $error("HOLD_MAX out of tenure counter range");
  end
  // Scan downward so the requester closest to ptr is the last (winning) assignment.
  always_comb begin
    win = ptr;
    for (int k = 3; k >= 0; k--)
      if (req[ptr + 2'(k)]) win = ptr + 2'(k);
  end
  assign gnt_idx   = {grant[3] | grant[2], grant[3] | grant[1]};
  assign gnt_valid = |grant;
  assign rel       = done | ~req[gnt_idx];
`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  assign tmo = ~rel && cnt == CNT_W'(HOLD_MAX - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt     <= state == GRANT ? cnt + 1'b1 : '0;
      timeout <= state == GRANT && tmo;
    end
`else
  assign tmo     = 1'b0;
  assign timeout = 1'b0;
`endif
  always_comb state_nx = state == IDLE ? (|req ? GRANT : IDLE) : (rel | tmo ? IDLE : GRANT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && |req) begin
        grant <= 4'b0001 << win;
        ptr   <= win + 2'd1;
      end else if (state == GRANT && (rel | tmo)) grant <= '0;
    end
endmodule
